chunked_adder: RTL and testbench
================================

Name: chunked_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a register.
- Successor to the fixed 4-bit ripple adder. Adds width/chunk parameters, add/sub mode, external carry-in, signed-overflow and zero flags, and valid/ready handshakes on both sides.
- Sits in the CPU datapath as the ALU add/sub engine where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 1.
- CHUNK, 4, bits added per cycle. Must divide WIDTH exactly; elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair is valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- sub  input  1  1: B is bit-inverted before the add.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n). All state and outputs are registered.
- Reset values:
  - FSM in IDLE.
  - in_ready=1, out_valid=0.
  - sum=0, cout=0, ovf=0, zero=0.
  - Internal chunk counter=0, carry register=0.
- Let N = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a rising edge, latch A=a, B=(sub ? ~b : b), carry=cin, counter=0, then go to RUN.
  - Subtraction A-B is sub=1 with cin=1. sub=1 with cin=0 gives A-B-1, for multiword borrow chaining.
- RUN:
  - in_ready=0.
  - Each cycle, compute chunk[counter] = A_chunk + B_chunk + carry. Write the CHUNK result bits into the sum register at that chunk position, and register the chunk carry-out as the new carry.
  - On the last chunk (counter==N-1):
    - cout = carry out of the MSB.
    - ovf = carry into the MSB XOR carry out of the MSB.
    - zero = (final sum == 0).
    - out_valid=1; go to DONE.
  - Otherwise counter+1.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout, ovf and zero are held stable while out_ready=0.
  - On out_ready=1 at an edge, out_valid=0 and go to IDLE.
  - Result outputs keep their value until overwritten by the next operation.
- Latency: with the handshake at edge k, out_valid is first high after edge k+N.
  - With out_ready held high, the next in_ready is high after edge k+N+1.
  - Throughput is one operation per N+2 cycles. No overlap of consecutive operations.
- During RUN the sum register holds partially updated bits. It is only meaningful when out_valid=1.
- a, b, cin, sub and in_valid are ignored outside the IDLE accept edge. Changes during RUN/DONE do not affect the result.
- out_ready is ignored outside DONE.
- CHUNK==WIDTH: RUN lasts one cycle (N=1).
- Reset mid-RUN or mid-DONE:
  - All registers return to reset values immediately (asynchronous).
  - The in-flight operation is discarded and no out_valid pulse appears.
  - Normal operation resumes from the first rising edge after rst_n deasserts.
- Wrap-around: sum is modulo 2^WIDTH; the carry appears only on cout.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. Assert rst_n=0 asynchronously mid-cycle -> immediately in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0.
2. Add a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid after exactly 4 edges; sum=0x5555, cout=0, ovf=0, zero=0.
3. Add a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1. Also add a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
4. Subtract a=0x7FFF, b=0xFFFF, sub=1, cin=1 -> sum=0x8000, cout=0, ovf=1. Subtract a=0x0005, b=0x0005, sub=1, cin=1 -> sum=0, cout=1, zero=1.
5. Backpressure: hold out_ready=0 for 6 cycles after out_valid, toggling a, b and in_valid meanwhile -> sum/flags stay stable, in_ready stays 0, no new operation accepted. Then out_ready=1 -> out_valid falls and in_ready rises the next cycle.
6. Assert rst_n=0 during RUN (counter=2) -> outputs reset instantly and no out_valid appears. After release, a=0x0F0F, b=0x00F1, cin=0, sub=0 -> sum=0x1000, cout=0, 4-cycle latency.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per
// clock, carrying between chunks through a register, with valid/ready on both sides.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_adder: CHUNK must divide WIDTH exactly");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_new;
  logic             msb_cin;

  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_c = a_q[i*CHUNK +: CHUNK];
        b_c = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ c_in.
    msb_cin = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ chunk_sum[CHUNK-1];
    sum_new = sum_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        sum_new[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = sum_new;
        carry_d = chunk_sum[CHUNK];
        if (cnt_q == LAST) begin
          cout_d      = chunk_sum[CHUNK];
          ovf_d       = msb_cin ^ chunk_sum[CHUNK];
          zero_d      = (sum_new == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder (WIDTH=16, CHUNK=4) with hand-computed results.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, ovf, zero;

  int tests = 0;
  int fails = 0;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  in_ready,  1);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".sum"},       sum,       0);
    check({tag, ".cout"},      cout,      0);
    check({tag, ".ovf"},       ovf,       0);
    check({tag, ".zero"},      zero,      0);
  endtask

  // Starts an operation just after a rising edge and waits (bounded) for out_valid.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic s, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez);
    int cycles;
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, in_ready, 0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, ".latency"}, cycles, 4);
    check({tag, ".sum"},  sum,  es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".ovf"},  ovf,  eo);
    check({tag, ".zero"}, zero, ez);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".vld_drop"}, out_valid, 0);
    check({tag, ".rdy_rise"}, in_ready,  1);
  endtask

  initial begin
    // Asynchronous reset asserted mid-cycle.
    #13 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_idle");

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    release_out("add_basic");
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out("add_wrap");
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    release_out("add_ovf");
    run_op("sub_ovf", 16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    release_out("sub_ovf");
    run_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out("sub_zero");
    run_op("sub_borrow", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    release_out("sub_borrow");

    // Backpressure: result must stay put while inputs churn.
    run_op("bp", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = 16'(16'hA5A5 + i); b = 16'(16'h5A5A - i); in_valid = i[0]; sub = ~i[0];
      @(posedge clk); #1;
      check("bp.sum",       sum,       16'h3334);
      check("bp.out_valid", out_valid, 1);
      check("bp.in_ready",  in_ready,  0);
      check("bp.flags",     {cout, ovf, zero}, 3'b000);
    end
    in_valid = 1'b0; sub = 1'b0;
    release_out("bp");
    check("bp.hold_after", sum, 16'h3334);

    // Reset while RUN has processed two chunks.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_run");
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_run.no_vld", out_valid, 0);
    end
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    release_out("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
